// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the two-requester RAM arbiter.
// Build option: RAM_ARB_RR_EN selects round-robin tie-break (default fixed A priority).
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } owner_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    function automatic int burst_w(input int mb);
        return $clog2(mb) + 1;
    endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner select: lock hold first, then single request, then tie-break.
// Build option: RAM_ARB_RR_EN makes ties round-robin on last_gnt.
module ram_arb_pick
    import ram_arb_pkg::*;
#(
    parameter int max_burst = 4,
    parameter int cw        = 3
) (
    input  logic          req_a,
    input  logic          req_b,
    input  logic          lock_a,
    input  logic          lock_b,
    input  owner_t        owner,
    input  logic [cw-1:0] burst_cnt,
    input  logic          last_gnt,
    output logic [1:0]    win,
    output logic          hold
);

`ifdef RAM_ARB_RR_EN
    localparam logic RR = 1'b1;
`else
    localparam logic RR = 1'b0;
`endif

    localparam logic [cw-1:0] LIM = cw'(max_burst - 1);

    logic hold_a;
    logic hold_b;
    logic tie_b;

    assign hold_a = (owner == OWN_A) && req_a && lock_a && (burst_cnt < LIM);
    assign hold_b = (owner == OWN_B) && req_b && lock_b && (burst_cnt < LIM);
    // Round-robin hands a tie to whoever was not granted last.
    assign tie_b  = RR && (last_gnt == REQ_A);

    always_comb begin
        win  = 2'b00;
        hold = 1'b0;
        priority case (1'b1)
            hold_a: begin
                win  = 2'b01;
                hold = 1'b1;
            end
            hold_b: begin
                win  = 2'b10;
                hold = 1'b1;
            end
            (req_a && req_b): win = tie_b ? 2'b10 : 2'b01;
            req_a:            win = 2'b01;
            req_b:            win = 2'b10;
            default:          win = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-requester arbiter/sequencer in front of a registered-read single-port RAM.
// Build option: RAM_ARB_RR_EN selects round-robin ties instead of fixed A priority.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int data_width = 32,
    parameter int addr_width = 4,
    parameter int max_burst  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_a,
    input  logic                  req_b,
    input  logic                  lock_a,
    input  logic                  lock_b,
    input  logic                  we_a,
    input  logic                  we_b,
    input  logic [addr_width-1:0] addr_a,
    input  logic [addr_width-1:0] addr_b,
    input  logic [data_width-1:0] wdata_a,
    input  logic [data_width-1:0] wdata_b,
    output logic                  gnt_a,
    output logic                  gnt_b,
    output logic                  rvalid_a,
    output logic                  rvalid_b,
    output logic [data_width-1:0] rdata,
    output logic [addr_width-1:0] ram_addr,
    output logic                  ram_we,
    output logic [data_width-1:0] ram_din,
    input  logic [data_width-1:0] ram_dout
);

    localparam int CW = burst_w(max_burst);

    owner_t                owner;
    owner_t                owner_nx;
    logic [CW-1:0]         burst_cnt;
    logic                  last_gnt;
    logic [addr_width-1:0] addr_q;
    logic [1:0]            win_raw;
    logic [1:0]            win;
    logic                  hold;

    ram_arb_pick #(
        .max_burst (max_burst),
        .cw        (CW)
    ) u_pick (
        .req_a     (req_a),
        .req_b     (req_b),
        .lock_a    (lock_a),
        .lock_b    (lock_b),
        .owner     (owner),
        .burst_cnt (burst_cnt),
        .last_gnt  (last_gnt),
        .win       (win_raw),
        .hold      (hold)
    );

    // Nothing is granted while reset is asserted.
    assign win   = reset_n ? win_raw : 2'b00;
    assign gnt_a = win[0];
    assign gnt_b = win[1];
    assign rdata = ram_dout;

    always_comb begin
        owner_nx = IDLE;
        ram_addr = addr_q;
        ram_we   = 1'b0;
        ram_din  = '0;
        if (win[0]) begin
            owner_nx = OWN_A;
            ram_addr = addr_a;
            ram_we   = we_a;
            ram_din  = wdata_a;
        end else if (win[1]) begin
            owner_nx = OWN_B;
            ram_addr = addr_b;
            ram_we   = we_b;
            ram_din  = wdata_b;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            owner <= IDLE;
        end else begin
            owner <= owner_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_gnt  <= REQ_B;
            burst_cnt <= '0;
            rvalid_a  <= 1'b0;
            rvalid_b  <= 1'b0;
            addr_q    <= '0;
        end else begin
            rvalid_a  <= gnt_a & ~we_a;
            rvalid_b  <= gnt_b & ~we_b;
            burst_cnt <= hold ? burst_cnt + 1'b1 : '0;
            if (|win) begin
                last_gnt <= win[1] ? REQ_B : REQ_A;
                addr_q   <= ram_addr;
            end
        end
    end

endmodule
